// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared constants and types for the five-stage MIPS core with CP0:
//            CP0 ExcCode values, default exception vector PC and the width of
//            the hazard T_new counter.
// Ports    : none (package)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef logic [4:0] exc_code_t;

    // CP0 Cause.ExcCode values produced or recognised in the E/M stages
    localparam exc_code_t EXC_NONE = 5'd0;
    localparam exc_code_t EXC_ADEL = 5'd4;
    localparam exc_code_t EXC_ADES = 5'd5;
    localparam exc_code_t EXC_OV   = 5'd12;

    // PC placed in the bubble created by an exception flush
    localparam logic [31:0] EXC_PC_DEF = 32'h0000_4180;

    // Width of the T_new hazard counter
    localparam int TNEW_W_DEF = 2;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/exc_merge_m.sv
`default_nettype none
// ============================================================================
// Module   : exc_merge_m
// Purpose  : Combinational merge of exceptions detected late in the E stage
//            into the ExcCode carried down the pipe, plus the kill signal that
//            suppresses architectural side effects of the excepting slot.
// Ports    : exc_code_in  - ExcCode accumulated up to E (0 = none)
//            ov           - ALU signed overflow
//            ov_check     - instruction traps on overflow (add/addi/sub)
//            mem_read     - load instruction
//            mem_write    - store instruction
//            exc_code_out - merged ExcCode
//            kill         - merged ExcCode is non-zero
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module exc_merge_m
    import cpu_pkg::*;
(
    input  logic [4:0] exc_code_in,
    input  logic       ov,
    input  logic       ov_check,
    input  logic       mem_read,
    input  logic       mem_write,
    output logic [4:0] exc_code_out,
    output logic       kill
);

    // Earlier-stage exceptions win; an overflowing address calculation is
    // reported as an address error of the matching access type. Overflow on
    // addu/addiu (no check flag, no memory access) is architecturally silent.
    always_comb begin
        exc_code_out = EXC_NONE;
        if (exc_code_in != EXC_NONE) begin
            exc_code_out = exc_code_in;
        end else if (ov && ov_check) begin
            exc_code_out = EXC_OV;
        end else if (ov && mem_read) begin
            exc_code_out = EXC_ADEL;
        end else if (ov && mem_write) begin
            exc_code_out = EXC_ADES;
        end
    end

    assign kill = (exc_code_out != EXC_NONE);

endmodule : exc_merge_m
`default_nettype wire

// File: rtl/reg_m.sv
`default_nettype none
// ============================================================================
// Module   : reg_m
// Purpose  : EX/MEM pipeline register. Latches E-stage results and forwarding
//            metadata, decrements T_new (saturating at 0), merges late E-stage
//            exceptions into ExcCode, supports hold (Stall) and exception
//            flush (Req, which loads EXC_PC into the bubble).
// Ports    : clk, reset (async, active-high), Req, Stall,
//            E-stage inputs *E / T_new_E / OvE / OvCheckE,
//            registered M-stage outputs *M / T_new_M / ExcCodeM.
// Config   : REG_M_DATA_TRACE_EN - adds TraceValidM / TraceAddrM outputs.
// Revision : 1.0 - initial release
// ============================================================================
module reg_m
    import cpu_pkg::*;
#(
    parameter logic [31:0] EXC_PC = EXC_PC_DEF,
    parameter int          TNEW_W = TNEW_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Req,
    input  logic              Stall,
    input  logic [31:0]       PcE,
    input  logic [31:0]       InstrE,
    input  logic              BDE,
    input  logic [31:0]       ALUOutE,
    input  logic [31:0]       WriteDataE,
    input  logic [4:0]        A3E,
    input  logic              RegWriteEnableE,
    input  logic              MemtoRegE,
    input  logic              MemWriteE,
    input  logic              MemReadE,
    input  logic              jalselE,
    input  logic [3:0]        MDUOpE,
    input  logic [31:0]       MDUOutE,
    input  logic [TNEW_W-1:0] T_new_E,
    input  logic [4:0]        ExcCodeE,
    input  logic              OvE,
    input  logic              OvCheckE,
    output logic [31:0]       PcM,
    output logic [31:0]       InstrM,
    output logic              BDM,
    output logic [31:0]       ALUOutM,
    output logic [31:0]       WriteDataM,
    output logic [4:0]        A3M,
    output logic              RegWriteEnableM,
    output logic              MemtoRegM,
    output logic              MemWriteM,
    output logic              MemReadM,
    output logic              jalselM,
    output logic [3:0]        MDUOpM,
    output logic [31:0]       MDUOutM,
    output logic [TNEW_W-1:0] T_new_M,
    output logic [4:0]        ExcCodeM
`ifdef REG_M_DATA_TRACE_EN
    ,
    output logic              TraceValidM,
    output logic [31:0]       TraceAddrM
`endif
);

    logic [4:0]        exc_merged;
    logic              kill;
    logic [TNEW_W-1:0] t_new_next;

    exc_merge_m u_exc_merge (
        .exc_code_in  (ExcCodeE),
        .ov           (OvE),
        .ov_check     (OvCheckE),
        .mem_read     (MemReadE),
        .mem_write    (MemWriteE),
        .exc_code_out (exc_merged),
        .kill         (kill)
    );

    // One stage of progress toward result availability; never wraps below 0
    assign t_new_next = (T_new_E != '0) ? (T_new_E - TNEW_W'(1)) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PcM             <= '0;
            InstrM          <= '0;
            BDM             <= 1'b0;
            ALUOutM         <= '0;
            WriteDataM      <= '0;
            A3M             <= '0;
            RegWriteEnableM <= 1'b0;
            MemtoRegM       <= 1'b0;
            MemWriteM       <= 1'b0;
            MemReadM        <= 1'b0;
            jalselM         <= 1'b0;
            MDUOpM          <= '0;
            MDUOutM         <= '0;
            T_new_M         <= '0;
            ExcCodeM        <= '0;
`ifdef REG_M_DATA_TRACE_EN
            TraceValidM     <= 1'b0;
            TraceAddrM      <= '0;
`endif
        end else if (Req) begin
            // Flush bubble: the exception vector PC keeps the M-stage PC
            // meaningful for a macroscopic-PC view while the slot is empty.
            PcM             <= EXC_PC;
            InstrM          <= '0;
            BDM             <= 1'b0;
            ALUOutM         <= '0;
            WriteDataM      <= '0;
            A3M             <= '0;
            RegWriteEnableM <= 1'b0;
            MemtoRegM       <= 1'b0;
            MemWriteM       <= 1'b0;
            MemReadM        <= 1'b0;
            jalselM         <= 1'b0;
            MDUOpM          <= '0;
            MDUOutM         <= '0;
            T_new_M         <= '0;
            ExcCodeM        <= '0;
`ifdef REG_M_DATA_TRACE_EN
            TraceValidM     <= 1'b0;
            TraceAddrM      <= '0;
`endif
        end else if (Stall) begin
            // Hold everything, T_new_M included; a held slot is not a new
            // trace event.
`ifdef REG_M_DATA_TRACE_EN
            TraceValidM     <= 1'b0;
`endif
        end else begin
            // PC/BD/Instr still latch on a killed slot for EPC and BD reporting
            PcM             <= PcE;
            InstrM          <= InstrE;
            BDM             <= BDE;
            ALUOutM         <= ALUOutE;
            WriteDataM      <= WriteDataE;
            A3M             <= A3E;
            RegWriteEnableM <= RegWriteEnableE & ~kill;
            MemtoRegM       <= MemtoRegE;
            MemWriteM       <= MemWriteE & ~kill;
            MemReadM        <= MemReadE & ~kill;
            jalselM         <= jalselE;
            MDUOpM          <= MDUOpE;
            MDUOutM         <= MDUOutE;
            T_new_M         <= t_new_next;
            ExcCodeM        <= exc_merged;
`ifdef REG_M_DATA_TRACE_EN
            TraceValidM     <= ~kill;
            TraceAddrM      <= (MemWriteE || MemReadE) ? ALUOutE : '0;
`endif
        end
    end

endmodule : reg_m
`default_nettype wire

// File: tb/tb_reg_m.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_m
// Purpose  : Directed self-checking bench for the EX/MEM pipeline register.
// Ports    : none
// Config   : REG_M_DATA_TRACE_EN - also connects and checks the trace outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_m;

    logic        clk;
    logic        reset;
    logic        Req;
    logic        Stall;
    logic [31:0] PcE;
    logic [31:0] InstrE;
    logic        BDE;
    logic [31:0] ALUOutE;
    logic [31:0] WriteDataE;
    logic [4:0]  A3E;
    logic        RegWriteEnableE;
    logic        MemtoRegE;
    logic        MemWriteE;
    logic        MemReadE;
    logic        jalselE;
    logic [3:0]  MDUOpE;
    logic [31:0] MDUOutE;
    logic [1:0]  T_new_E;
    logic [4:0]  ExcCodeE;
    logic        OvE;
    logic        OvCheckE;
    logic [31:0] PcM;
    logic [31:0] InstrM;
    logic        BDM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [4:0]  A3M;
    logic        RegWriteEnableM;
    logic        MemtoRegM;
    logic        MemWriteM;
    logic        MemReadM;
    logic        jalselM;
    logic [3:0]  MDUOpM;
    logic [31:0] MDUOutM;
    logic [1:0]  T_new_M;
    logic [4:0]  ExcCodeM;
`ifdef REG_M_DATA_TRACE_EN
    logic        TraceValidM;
    logic [31:0] TraceAddrM;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    reg_m dut (
        .clk             (clk),
        .reset           (reset),
        .Req             (Req),
        .Stall           (Stall),
        .PcE             (PcE),
        .InstrE          (InstrE),
        .BDE             (BDE),
        .ALUOutE         (ALUOutE),
        .WriteDataE      (WriteDataE),
        .A3E             (A3E),
        .RegWriteEnableE (RegWriteEnableE),
        .MemtoRegE       (MemtoRegE),
        .MemWriteE       (MemWriteE),
        .MemReadE        (MemReadE),
        .jalselE         (jalselE),
        .MDUOpE          (MDUOpE),
        .MDUOutE         (MDUOutE),
        .T_new_E         (T_new_E),
        .ExcCodeE        (ExcCodeE),
        .OvE             (OvE),
        .OvCheckE        (OvCheckE),
        .PcM             (PcM),
        .InstrM          (InstrM),
        .BDM             (BDM),
        .ALUOutM         (ALUOutM),
        .WriteDataM      (WriteDataM),
        .A3M             (A3M),
        .RegWriteEnableM (RegWriteEnableM),
        .MemtoRegM       (MemtoRegM),
        .MemWriteM       (MemWriteM),
        .MemReadM        (MemReadM),
        .jalselM         (jalselM),
        .MDUOpM          (MDUOpM),
        .MDUOutM         (MDUOutM),
        .T_new_M         (T_new_M),
        .ExcCodeM        (ExcCodeM)
`ifdef REG_M_DATA_TRACE_EN
        ,
        .TraceValidM     (TraceValidM),
        .TraceAddrM      (TraceAddrM)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Req = 1'b0; Stall = 1'b0;
        PcE = '0; InstrE = '0; BDE = 1'b0; ALUOutE = '0; WriteDataE = '0;
        A3E = '0; RegWriteEnableE = 1'b0; MemtoRegE = 1'b0; MemWriteE = 1'b0;
        MemReadE = 1'b0; jalselE = 1'b0; MDUOpE = '0; MDUOutE = '0;
        T_new_E = '0; ExcCodeE = '0; OvE = 1'b0; OvCheckE = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".PcM"},   PcM, 32'h0);
        check({tag, ".ctrl"},  {27'h0, RegWriteEnableM, MemWriteM, MemReadM, MemtoRegM, jalselM}, 32'h0);
        check({tag, ".data"},  ALUOutM | WriteDataM | InstrM | MDUOutM, 32'h0);
        check({tag, ".tnew"},  {30'h0, T_new_M}, 32'h0);
        check({tag, ".exc"},   {27'h0, ExcCodeM}, 32'h0);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        reset = 1'b0;

        // Plain load with T_new decrement
        PcE = 32'h3000; InstrE = 32'h0123_4567; ALUOutE = 32'hAAAA_0001;
        WriteDataE = 32'h5555_0002; A3E = 5'd5; RegWriteEnableE = 1'b1;
        MDUOpE = 4'd3; MDUOutE = 32'hDEAD_BEEF; T_new_E = 2'd2;
        step();
        check("load.PcM", PcM, 32'h3000);
        check("load.tnew", {30'h0, T_new_M}, 32'd1);
        check("load.ALUOutM", ALUOutM, 32'hAAAA_0001);
        check("load.A3M_RegWr", {26'h0, A3M, RegWriteEnableM}, {26'h0, 5'd5, 1'b1});
        check("load.MDU", MDUOutM ^ {28'h0, MDUOpM}, 32'hDEAD_BEEF ^ 32'd3);
`ifdef REG_M_DATA_TRACE_EN
        check("load.trace_valid", {31'h0, TraceValidM}, 32'd1);
        check("load.trace_addr", TraceAddrM, 32'h0);
`endif

        T_new_E = 2'd0;
        step();
        check("tnew_sat0", {30'h0, T_new_M}, 32'd0);

        // Prime with T_new 3 -> 2 and BD set, then stall for three cycles
        PcE = 32'h3004; T_new_E = 2'd3; BDE = 1'b1;
        step();
        check("prime.tnew", {30'h0, T_new_M}, 32'd2);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            PcE = 32'h3100 + 32'(i * 4); T_new_E = 2'(i); BDE = 1'b0;
            RegWriteEnableE = 1'b0; ALUOutE = 32'h1234_0000 + 32'(i);
            step();
            check("stall.PcM", PcM, 32'h3004);
            check("stall.tnew", {30'h0, T_new_M}, 32'd2);
            check("stall.BD_RegWr", {30'h0, BDM, RegWriteEnableM}, 32'd3);
        end
`ifdef REG_M_DATA_TRACE_EN
        check("stall.trace_valid", {31'h0, TraceValidM}, 32'd0);
`endif

        // Req overrides Stall
        Req = 1'b1; RegWriteEnableE = 1'b1; ExcCodeE = 5'd10; BDE = 1'b1;
        step();
        check("req.PcM", PcM, 32'h0000_4180);
        check("req.BD_RegWr", {30'h0, BDM, RegWriteEnableM}, 32'd0);
        check("req.exc", {27'h0, ExcCodeM}, 32'd0);
        check("req.data", ALUOutM | {30'h0, T_new_M}, 32'h0);
        idle_inputs();

        // Checked overflow -> Ov, killed
        PcE = 32'h3010; OvE = 1'b1; OvCheckE = 1'b1; RegWriteEnableE = 1'b1; BDE = 1'b1;
        step();
        check("ov.exc", {27'h0, ExcCodeM}, 32'd12);
        check("ov.RegWr", {31'h0, RegWriteEnableM}, 32'd0);
        check("ov.PcM_BD", PcM ^ {31'h0, BDM}, 32'h3011);
`ifdef REG_M_DATA_TRACE_EN
        check("ov.trace_valid", {31'h0, TraceValidM}, 32'd0);
`endif

        ExcCodeE = 5'd10;
        step();
        check("ov_prior.exc", {27'h0, ExcCodeM}, 32'd10);
        check("ov_prior.RegWr", {31'h0, RegWriteEnableM}, 32'd0);
        idle_inputs();

        // Address-calculation overflow on a store / load
        OvE = 1'b1; MemWriteE = 1'b1; ALUOutE = 32'h8000_0000;
        step();
        check("ades.exc", {27'h0, ExcCodeM}, 32'd5);
        check("ades.MemWr", {31'h0, MemWriteM}, 32'd0);
        MemWriteE = 1'b0; MemReadE = 1'b1; RegWriteEnableE = 1'b1;
        step();
        check("adel.exc", {27'h0, ExcCodeM}, 32'd4);
        check("adel.MemRd_RegWr", {30'h0, MemReadM, RegWriteEnableM}, 32'd0);

        // Unchecked overflow (addu) passes through
        MemReadE = 1'b0; RegWriteEnableE = 1'b1; MemtoRegE = 1'b0; A3E = 5'd9;
        step();
        check("addu.exc", {27'h0, ExcCodeM}, 32'd0);
        check("addu.RegWr", {31'h0, RegWriteEnableM}, 32'd1);

        // Non-overflow store passes through; trace address captured
        OvE = 1'b0; RegWriteEnableE = 1'b0; MemWriteE = 1'b1; ALUOutE = 32'h0000_2004;
        WriteDataE = 32'hCAFE_F00D;
        step();
        check("sw.MemWr", {31'h0, MemWriteM}, 32'd1);
        check("sw.WriteData", WriteDataM, 32'hCAFE_F00D);
`ifdef REG_M_DATA_TRACE_EN
        check("sw.trace_addr", TraceAddrM, 32'h0000_2004);
`endif

        // Asynchronous reset mid-cycle with loaded registers
        PcE = 32'h3020; T_new_E = 2'd2;
        step();
        #2 reset = 1'b1;
        #1;
        check_cleared("async_reset");
        // Reset during stall; stays empty after release while stalled
        Stall = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("post_reset_stall.PcM", PcM, 32'h0);
        check("post_reset_stall.tnew", {30'h0, T_new_M}, 32'd0);
        Stall = 1'b0;
        step();
        check("post_reset_load.PcM", PcM, 32'h3020);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_reg_m
`default_nettype wire
